switch_scanner: RTL and testbench

Multi-channel switch front end that owns sampling and event generation for a bank of bouncy switches. Each cycle of a periodic scan processes one channel, so a single filter datapath is time-shared across all channels. Each channel gets synchronization, a counter-based debounce filter and long-press detection. Resulting press/release/long-press events are arbitrated round-robin onto one valid/ready event stream for a CPU or UI block.

---
 rtl/switch_scanner_if.sv | 12 +
 rtl/switch_scanner.sv | 199 +++++++++++++++++++
 tb/tb_switch_scanner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/switch_scanner_if.sv
// Event stream from the switch scanner: valid/ready handshake carrying channel and event type.
interface switch_scanner_if #(
  parameter int unsigned CH_BITS = 2
);
  logic               event_valid;
  logic               event_ready;
  logic [CH_BITS-1:0] event_channel;
  logic [1:0]         event_type;

  modport master (output event_valid, event_channel, event_type, input event_ready);
  modport slave  (input event_valid, event_channel, event_type, output event_ready);
endinterface

// File: rtl/switch_scanner.sv
// Time-shared debounce and long-press filter over a bank of switches, with a
// round-robin arbitrated press/release/long-press event stream.
module switch_scanner #(
  parameter int unsigned NUM_INPUTS           = 4,
  parameter int unsigned SAMPLE_PERIOD        = 1000,
  parameter int unsigned FILTER_COUNTER_MAX   = 3,
  parameter int unsigned SYNCHRONIZE_FF_DEPTH = 2,
  parameter int unsigned LONG_PRESS_SAMPLES   = 500,
  localparam int unsigned CH_BITS = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] async_in,
  output logic [NUM_INPUTS-1:0] level_out,
  output logic                  overflow,
  input  logic                  clear_overflow,
  switch_scanner_if.master      evt
);
  localparam int unsigned PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned FW = (FILTER_COUNTER_MAX > 0) ? $clog2(FILTER_COUNTER_MAX + 1) : 1;
  localparam int unsigned HW = $clog2(LONG_PRESS_SAMPLES + 1);
  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;
  localparam logic [1:0] EV_LONG    = 2'b11;

  if (NUM_INPUTS < 1) begin : g_chk_num
    $error("NUM_INPUTS must be >= 1");
  end
  if (SAMPLE_PERIOD < NUM_INPUTS + 1) begin : g_chk_period
    $error("SAMPLE_PERIOD must be >= NUM_INPUTS+1");
  end
  if (SYNCHRONIZE_FF_DEPTH < 2) begin : g_chk_sync
    $error("SYNCHRONIZE_FF_DEPTH must be >= 2");
  end
  if (LONG_PRESS_SAMPLES < 1) begin : g_chk_long
    $error("LONG_PRESS_SAMPLES must be >= 1");
  end

  typedef enum logic {ST_IDLE, ST_SCAN} state_e;

  logic [NUM_INPUTS-1:0] sync_q [SYNCHRONIZE_FF_DEPTH];
  logic [PW-1:0]         presc_q;
  state_e                state_q;
  logic [CH_BITS-1:0]    idx_q, ptr_q;
  logic [FW-1:0]         cnt_q  [NUM_INPUTS];
  logic [HW-1:0]         hold_q [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] level_q, press_q, long_q, rel_q;
  logic                  ev_valid_q, ovf_q;
  logic [CH_BITS-1:0]    ev_ch_q;
  logic [1:0]            ev_type_q;

  logic                  tick_c, scan_c, s_c, lvl_c, lvl_new_c, flip_c, long_hit_c;
  logic [FW-1:0]         cnt_c, cnt_new_c;
  logic [HW-1:0]         hold_c, hold_new_c;
  logic [NUM_INPUTS-1:0] sel_c, sp_c, sl_c, sr_c, gp_c, gl_c, gr_c, gnt_sel_c;
  logic [NUM_INPUTS-1:0] press_d, long_d, rel_d;
  logic                  load_c, found_c, ovf_set_c;
  logic [CH_BITS-1:0]    gnt_ch_c;
  logic [1:0]            gnt_type_c;

  assign tick_c = (presc_q == PW'(SAMPLE_PERIOD - 1));
  assign scan_c = (state_q == ST_SCAN);
  assign sel_c  = NUM_INPUTS'(1) << idx_q;

  // Shared filter datapath for the channel in the current scan slot.
  always_comb begin
    s_c        = sync_q[SYNCHRONIZE_FF_DEPTH-1][idx_q];
    lvl_c      = level_q[idx_q];
    cnt_c      = cnt_q[idx_q];
    hold_c     = hold_q[idx_q];
    cnt_new_c  = '0;
    lvl_new_c  = lvl_c;
    flip_c     = 1'b0;
    hold_new_c = '0;
    long_hit_c = 1'b0;
    if (s_c != lvl_c) begin
      if (cnt_c >= FW'(FILTER_COUNTER_MAX)) begin
        lvl_new_c = s_c;
        flip_c    = 1'b1;
      end else begin
        cnt_new_c = cnt_c + FW'(1);
      end
    end
    if (lvl_new_c) begin
      if (hold_c < HW'(LONG_PRESS_SAMPLES)) begin
        hold_new_c = hold_c + HW'(1);
        long_hit_c = (hold_new_c == HW'(LONG_PRESS_SAMPLES));
      end else begin
        hold_new_c = hold_c;
      end
    end
  end

  assign sp_c = (scan_c && flip_c &&  lvl_new_c) ? sel_c : '0;
  assign sr_c = (scan_c && flip_c && !lvl_new_c) ? sel_c : '0;
  assign sl_c = (scan_c && long_hit_c)           ? sel_c : '0;

  // Round-robin search starting after the last granted channel; press > long > release.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    found_c    = 1'b0;
    gnt_ch_c   = '0;
    gnt_type_c = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      cand = (32'(ptr_q) + i + 32'd1) % NUM_INPUTS;
      if (!found_c && (press_q[CH_BITS'(cand)] || long_q[CH_BITS'(cand)] || rel_q[CH_BITS'(cand)])) begin
        found_c  = 1'b1;
        gnt_ch_c = CH_BITS'(cand);
        if (press_q[CH_BITS'(cand)])     gnt_type_c = EV_PRESS;
        else if (long_q[CH_BITS'(cand)]) gnt_type_c = EV_LONG;
        else                             gnt_type_c = EV_RELEASE;
      end
    end
  end

  assign load_c    = !ev_valid_q || evt.event_ready;
  assign gnt_sel_c = NUM_INPUTS'(1) << gnt_ch_c;
  assign gp_c = (load_c && found_c && gnt_type_c == EV_PRESS)   ? gnt_sel_c : '0;
  assign gl_c = (load_c && found_c && gnt_type_c == EV_LONG)    ? gnt_sel_c : '0;
  assign gr_c = (load_c && found_c && gnt_type_c == EV_RELEASE) ? gnt_sel_c : '0;

  // A set landing on a still-pending bit loses that event; a same-cycle set wins over the grant.
  assign press_d   = (press_q & ~gp_c) | sp_c;
  assign long_d    = (long_q  & ~gl_c) | sl_c;
  assign rel_d     = (rel_q   & ~gr_c) | sr_c;
  assign ovf_set_c = |((press_q & ~gp_c & sp_c) | (long_q & ~gl_c & sl_c) | (rel_q & ~gr_c & sr_c));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNCHRONIZE_FF_DEPTH); i++) sync_q[i] <= '0;
      for (int i = 0; i < int'(NUM_INPUTS); i++) begin
        cnt_q[i]  <= '0;
        hold_q[i] <= '0;
      end
      presc_q    <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      ptr_q      <= '0;
      level_q    <= '0;
      press_q    <= '0;
      long_q     <= '0;
      rel_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_type_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < int'(SYNCHRONIZE_FF_DEPTH); i++) sync_q[i] <= sync_q[i-1];

      if (!enable)     presc_q <= '0;
      else if (tick_c) presc_q <= '0;
      else             presc_q <= presc_q + PW'(1);

      case (state_q)
        ST_IDLE: if (tick_c) begin
          state_q <= ST_SCAN;
          idx_q   <= '0;
        end
        ST_SCAN: begin
          if (idx_q == CH_BITS'(NUM_INPUTS - 1)) state_q <= ST_IDLE;
          else                                   idx_q   <= idx_q + CH_BITS'(1);
        end
        default: state_q <= ST_IDLE;
      endcase

      if (scan_c) begin
        level_q[idx_q] <= lvl_new_c;
        cnt_q[idx_q]   <= cnt_new_c;
        hold_q[idx_q]  <= hold_new_c;
      end

      press_q <= press_d;
      long_q  <= long_d;
      rel_q   <= rel_d;

      if (load_c) begin
        ev_valid_q <= found_c;
        if (found_c) begin
          ev_ch_q   <= gnt_ch_c;
          ev_type_q <= gnt_type_c;
          ptr_q     <= gnt_ch_c;
        end
      end

      if (ovf_set_c)           ovf_q <= 1'b1;
      else if (clear_overflow) ovf_q <= 1'b0;
    end
  end

  assign level_out         = level_q;
  assign overflow          = ovf_q;
  assign evt.event_valid   = ev_valid_q;
  assign evt.event_channel = ev_ch_q;
  assign evt.event_type    = ev_type_q;

endmodule

// File: tb/tb_switch_scanner.sv
// Directed bench for switch_scanner: expected events queued at stimulus time, popped by a monitor.
module tb_switch_scanner;
  localparam logic [1:0] EP = 2'b01;
  localparam logic [1:0] ER = 2'b10;
  localparam logic [1:0] EL = 2'b11;

  logic       clock = 1'b0;
  logic       reset_n, enable, clear_overflow;
  logic [3:0] async_in, level_out;
  logic       overflow;

  logic [3:0] exp_q[$];
  int         acc_q[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  switch_scanner_if #(.CH_BITS(2)) ev_if ();

  switch_scanner #(
    .NUM_INPUTS(4), .SAMPLE_PERIOD(8), .FILTER_COUNTER_MAX(3),
    .SYNCHRONIZE_FF_DEPTH(2), .LONG_PRESS_SAMPLES(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .async_in(async_in),
    .level_out(level_out), .overflow(overflow), .clear_overflow(clear_overflow),
    .evt(ev_if)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
    end
  endtask

  // One scan period per call; called at the phase where input changes cannot split a scan.
  task automatic steps(input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      async_in = v;
      repeat (8) @(negedge clock);
    end
  endtask

  task automatic push_ev(input logic [1:0] ch, input logic [1:0] ty);
    exp_q.push_back({ch, ty});
  endtask

  // Monitor: one pop per accepted event, sampled between edges.
  initial forever begin
    @(negedge clock);
    #1;
    if (reset_n && ev_if.event_valid && ev_if.event_ready) begin
      acc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_event", 32'({ev_if.event_channel, ev_if.event_type}), 32'hFF);
      end else begin
        check("event", 32'({ev_if.event_channel, ev_if.event_type}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; async_in = '0; clear_overflow = 1'b0;
    ev_if.event_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_level", 32'(level_out), 0);
    check("rst_valid", 32'(ev_if.event_valid), 0);
    check("rst_ch_type", 32'({ev_if.event_channel, ev_if.event_type}), 0);
    check("rst_overflow", 32'(overflow), 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Bounce on ch0, then clean release.
    push_ev(2'd0, EP);
    steps(4'b0000, 1); steps(4'b0001, 1); steps(4'b0000, 1);
    steps(4'b0001, 3);
    check("bounce_level_before", 32'(level_out), 0);
    repeat (3) @(negedge clock);
    check("bounce_level_tick", 32'(level_out[0]), 0);
    @(negedge clock);
    check("bounce_level_slot0", 32'(level_out[0]), 1);
    repeat (4) @(negedge clock);
    push_ev(2'd0, ER);
    steps(4'b0000, 3);
    check("release_level_hold", 32'(level_out), 32'h1);
    steps(4'b0000, 1);
    check("release_level", 32'(level_out), 0);

    // Long press on ch2: press, one long, release.
    push_ev(2'd2, EP); push_ev(2'd2, EL); push_ev(2'd2, ER);
    steps(4'b0100, 4);
    check("long_level_up", 32'(level_out), 32'h4);
    steps(4'b0100, 6);
    steps(4'b0000, 4);
    check("long_level_down", 32'(level_out), 0);
    check("long_queue_empty", 32'(exp_q.size()), 0);

    // Round robin under backpressure.
    ev_if.event_ready = 1'b0;
    push_ev(2'd1, EP); push_ev(2'd3, EP); push_ev(2'd1, ER); push_ev(2'd3, ER);
    steps(4'b1010, 4);
    async_in = 4'b0000;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      check("rr_hold_stable", 32'({ev_if.event_valid, ev_if.event_channel, ev_if.event_type}), 32'h15);
    end
    acc_q.delete();
    ev_if.event_ready = 1'b1;
    steps(4'b0000, 1);
    check("rr_accept_count", 32'(acc_q.size()), 4);
    check("rr_back_to_back", (acc_q.size() == 4) ? 32'(acc_q[3] - acc_q[0]) : 32'hFF, 3);
    check("rr_idle_valid", 32'(ev_if.event_valid), 0);

    // Overflow: second press on ch0 while the first is still pending.
    ev_if.event_ready = 1'b0;
    push_ev(2'd1, EP); push_ev(2'd0, EP); push_ev(2'd1, ER); push_ev(2'd0, ER);
    steps(4'b0010, 4);
    steps(4'b0001, 4);
    steps(4'b0000, 4);
    check("ovf_before", 32'(overflow), 0);
    steps(4'b0001, 4);
    check("ovf_set", 32'(overflow), 1);
    async_in = 4'b0000;
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    @(negedge clock);
    check("ovf_cleared", 32'(overflow), 0);
    repeat (6) @(negedge clock);
    steps(4'b0000, 2);
    clear_overflow = 1'b1;
    repeat (4) @(negedge clock);
    check("ovf_set_beats_clear", 32'(overflow), 1);
    clear_overflow = 1'b0;
    repeat (4) @(negedge clock);
    check("ovf_sticky", 32'(overflow), 1);
    ev_if.event_ready = 1'b1;
    steps(4'b0000, 1);
    check("ovf_drain_empty", 32'(exp_q.size()), 0);
    check("ovf_idle_valid", 32'(ev_if.event_valid), 0);

    // Scanning disabled: input activity must not reach the filter.
    enable = 1'b0;
    steps(4'b1000, 1); steps(4'b0000, 1); steps(4'b1000, 5);
    check("disabled_level", 32'(level_out), 0);
    check("disabled_valid", 32'(ev_if.event_valid), 0);
    steps(4'b0000, 1);
    enable = 1'b1;
    repeat (5) @(negedge clock);

    // Asynchronous reset with an event held and counters mid-count.
    ev_if.event_ready = 1'b0;
    steps(4'b0100, 4);
    steps(4'b0101, 2);
    check("pre_reset_valid", 32'(ev_if.event_valid), 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_level", 32'(level_out), 0);
    check("arst_valid", 32'(ev_if.event_valid), 0);
    check("arst_ch_type", 32'({ev_if.event_channel, ev_if.event_type}), 0);
    check("arst_overflow", 32'(overflow), 0);
    async_in = 4'b0001;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ev_if.event_ready = 1'b1;
    repeat (5) @(negedge clock);
    push_ev(2'd0, EP);
    steps(4'b0001, 3);
    check("post_reset_level_wait", 32'(level_out), 0);
    steps(4'b0001, 1);
    check("post_reset_level_flip", 32'(level_out), 32'h1);
    push_ev(2'd0, ER);
    steps(4'b0000, 5);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
